// File: rtl/hnf_txreq_qos_arb.sv
// HN-F TXREQ arbiter: QoS ordering, round-robin tie-break and age-based
// anti-starvation, gated by link-credit availability; winner flit registered to link.
`ifndef CHIE_REQ_FLIT_WIDTH
`define CHIE_REQ_FLIT_WIDTH 64
`endif
`ifndef CHIE_REQ_FLIT_QOS_WIDTH
`define CHIE_REQ_FLIT_QOS_WIDTH 4
`endif

module hnf_txreq_qos_arb #(
  parameter int NUM_REQ       = 4,
  parameter int FLIT_WIDTH    = `CHIE_REQ_FLIT_WIDTH,
  parameter int QOS_WIDTH     = `CHIE_REQ_FLIT_QOS_WIDTH,
  parameter int AGE_WIDTH     = 4,
  parameter int STARVE_THRESH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            crd_avail_s1,
  input  logic [NUM_REQ-1:0]              req_valid_s1,
  input  logic [NUM_REQ*QOS_WIDTH-1:0]    req_qos_s1,
  input  logic [NUM_REQ*FLIT_WIDTH-1:0]   req_flit_s1,
  output logic [NUM_REQ-1:0]              arb_won_s1,
  output logic                            txreqflitv,
  output logic [FLIT_WIDTH-1:0]           txreqflit,
  output logic                            arb_starve_s1
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [AGE_WIDTH-1:0] THRESH = AGE_WIDTH'(STARVE_THRESH);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]     rr_ptr;
  logic [AGE_WIDTH-1:0] age [NUM_REQ];

  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   at_thresh;
  logic [NUM_REQ-1:0]   starved;
  logic [NUM_REQ-1:0]   qos_set;
  logic [NUM_REQ-1:0]   cls;
  logic [QOS_WIDTH-1:0] max_qos;
  logic                 win_found;
  logic [PTR_W-1:0]     win_idx;
  int                   j;

  always_comb begin
    eligible  = req_valid_s1 & {NUM_REQ{crd_avail_s1}};
    at_thresh = '0;
    max_qos   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      at_thresh[i] = (age[i] == THRESH);
      if (eligible[i] && (req_qos_s1[i*QOS_WIDTH +: QOS_WIDTH] > max_qos))
        max_qos = req_qos_s1[i*QOS_WIDTH +: QOS_WIDTH];
    end
    starved = eligible & at_thresh;
    qos_set = '0;
    for (int i = 0; i < NUM_REQ; i++)
      qos_set[i] = eligible[i] && (req_qos_s1[i*QOS_WIDTH +: QOS_WIDTH] == max_qos);
    cls = (|starved) ? starved : qos_set;

    // Rotating search from rr_ptr; explicit modulo handles non-power-of-2 NUM_REQ.
    win_found = 1'b0;
    win_idx   = '0;
    j         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(rr_ptr) + k) % NUM_REQ;
      if (!win_found && cls[j]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(j);
      end
    end

    arb_won_s1 = '0;
    if (win_found && !rst)
      arb_won_s1[win_idx] = 1'b1;
  end

  assign arb_starve_s1 = |(req_valid_s1 & at_thresh);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= '0;
      txreqflitv <= 1'b0;
      txreqflit  <= '0;
      for (int i = 0; i < NUM_REQ; i++) age[i] <= '0;
    end else begin
      txreqflitv <= win_found;
      if (win_found) begin
        txreqflit <= req_flit_s1[win_idx*FLIT_WIDTH +: FLIT_WIDTH];
        rr_ptr    <= (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (arb_won_s1[i] || !req_valid_s1[i])
          age[i] <= '0;
        else if (crd_avail_s1 && (age[i] != THRESH))
          age[i] <= age[i] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hnf_txreq_qos_arb.sv
// Self-checking bench for hnf_txreq_qos_arb: random and directed traffic
// compared against a list-based reference model of the arbitration rules.
module tb_hnf_txreq_qos_arb;
  localparam int N  = 4;
  localparam int FW = 64;
  localparam int QW = 4;
  localparam int T  = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            crd_avail_s1 = 1'b0;
  logic [N-1:0]    req_valid_s1 = '0;
  logic [N*QW-1:0] req_qos_s1 = '0;
  logic [N*FW-1:0] req_flit_s1 = '0;
  logic [N-1:0]    arb_won_s1;
  logic            txreqflitv;
  logic [FW-1:0]   txreqflit;
  logic            arb_starve_s1;

  hnf_txreq_qos_arb #(.NUM_REQ(N), .FLIT_WIDTH(FW), .QOS_WIDTH(QW),
                      .AGE_WIDTH(4), .STARVE_THRESH(T)) dut (
    .clk(clk), .rst(rst), .crd_avail_s1(crd_avail_s1),
    .req_valid_s1(req_valid_s1), .req_qos_s1(req_qos_s1),
    .req_flit_s1(req_flit_s1), .arb_won_s1(arb_won_s1),
    .txreqflitv(txreqflitv), .txreqflit(txreqflit),
    .arb_starve_s1(arb_starve_s1));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int          m_age [N];
  int          m_rr;
  logic        m_v;
  logic [FW-1:0] m_flit;
  int          last_g;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int qos_of(int i);
    return int'(req_qos_s1[i*QW +: QW]);
  endfunction

  // Winner = class member closest to rr pointer going upward (circular distance).
  function automatic int model_pick();
    int cand[$];
    int maxq;
    int best;
    int bestd;
    int d;
    if (!crd_avail_s1) return -1;
    for (int i = 0; i < N; i++)
      if (req_valid_s1[i] && m_age[i] == T) cand.push_back(i);
    if (cand.size() == 0) begin
      maxq = -1;
      for (int i = 0; i < N; i++)
        if (req_valid_s1[i] && qos_of(i) > maxq) maxq = qos_of(i);
      for (int i = 0; i < N; i++)
        if (req_valid_s1[i] && qos_of(i) == maxq) cand.push_back(i);
    end
    best = -1;
    bestd = N;
    foreach (cand[k]) begin
      d = (cand[k] - m_rr + N) % N;
      if (d < bestd) begin bestd = d; best = cand[k]; end
    end
    return best;
  endfunction

  function automatic logic model_starve();
    for (int i = 0; i < N; i++)
      if (req_valid_s1[i] && m_age[i] == T) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_age[i] = 0;
    m_rr = 0;
    m_v = 1'b0;
    m_flit = '0;
  endtask

  // Entered at a negedge; leaves at the following negedge.
  task automatic cycle(input logic [N-1:0] v, input logic c, input logic [N*QW-1:0] q);
    logic [N-1:0] exp_won;
    int g;
    req_valid_s1 = v;
    crd_avail_s1 = c;
    req_qos_s1   = q;
    for (int i = 0; i < N; i++)
      req_flit_s1[i*FW +: FW] = {$urandom, $urandom};
    #1;
    g = model_pick();
    exp_won = '0;
    if (g >= 0) exp_won[g] = 1'b1;
    chk("arb_won", 64'(arb_won_s1), 64'(exp_won));
    chk("arb_starve", 64'(arb_starve_s1), 64'(model_starve()));
    last_g = g;
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (i == g || !v[i]) m_age[i] = 0;
      else if (c && m_age[i] < T) m_age[i]++;
    end
    m_v = (g >= 0);
    if (g >= 0) begin
      m_flit = req_flit_s1[g*FW +: FW];
      m_rr = (g + 1) % N;
    end
    @(negedge clk);
    chk("txreqflitv", 64'(txreqflitv), 64'(m_v));
    chk("txreqflit", txreqflit, m_flit);
  endtask

  task automatic do_reset();
    req_valid_s1 = '1;
    crd_avail_s1 = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_flitv", 64'(txreqflitv), 64'd0);
    chk("rst_flit", txreqflit, 64'd0);
    chk("rst_won", 64'(arb_won_s1), 64'd0);
    req_valid_s1 = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  int g3_wins;

  initial begin
    model_reset();
    last_g = -1;
    req_valid_s1 = '1;
    crd_avail_s1 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("init_flitv", 64'(txreqflitv), 64'd0);
    chk("init_flit", txreqflit, 64'd0);
    chk("init_won", 64'(arb_won_s1), 64'd0);
    req_valid_s1 = '0;
    rst = 1'b0;

    // Single source, back-to-back
    for (int k = 0; k < 3; k++) begin
      cycle(4'b0001, 1'b1, 16'h0000);
      chk("single_grant", 64'(last_g), 64'd0);
    end
    // QoS ordering
    cycle(4'b0011, 1'b1, 16'h0092);
    chk("qos_winner", 64'(last_g), 64'd1);
    // Equal QoS round-robin
    for (int k = 0; k < 8; k++) cycle(4'b1111, 1'b1, 16'h5555);

    // Starvation: req0 qos15 vs req3 qos0 from fresh ages
    do_reset();
    g3_wins = 0;
    for (int k = 0; k < T; k++) begin
      cycle(4'b1001, 1'b1, 16'h000F);
      if (last_g == 3) g3_wins++;
    end
    chk("starve_early_wins", 64'(g3_wins), 64'd0);
    cycle(4'b1001, 1'b1, 16'h000F);
    chk("starve_grant", 64'(last_g), 64'd3);

    // No credit then resume
    for (int k = 0; k < 5; k++) cycle(4'b1111, 1'b0, 16'h1234);
    cycle(4'b1111, 1'b1, 16'h1111);

    // Several starved requesters rotate
    for (int k = 0; k < 40; k++) cycle(4'b1111, 1'b1, 16'h05AF);

    // Random traffic with occasional mid-stream reset
    for (int k = 0; k < 400; k++) begin
      if (k % 97 == 50 && txreqflitv) begin
        do_reset();
        cycle(4'b1000, 1'b1, 16'(($urandom)));
        chk("post_rst_grant", 64'(last_g), 64'd3);
      end else begin
        cycle(4'($urandom), ($urandom_range(0, 9) < 8),
              (k % 3 == 0) ? 16'($urandom) : 16'($urandom) & 16'h1111);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1);
  end
endmodule
